// File: rtl/fa_rr_scheduler_if.sv
// Bus between the round-robin scheduler, its four requesters and the shared 8-bit adder.
interface fa_rr_scheduler_if;
  logic [3:0]  req;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic [7:0]  res;
  logic        res_carry;
  logic [7:0]  fa_a;
  logic [7:0]  fa_b;
  logic [7:0]  fa_sum;
  logic        fa_cout;
  logic        busy;

  // Scheduler side
  modport slave (
    input  req, req_a, req_b, fa_sum, fa_cout,
    output gnt, ack, res, res_carry, fa_a, fa_b, busy
  );

  // Requesters plus adder side
  modport master (
    output req, req_a, req_b, fa_sum, fa_cout,
    input  gnt, ack, res, res_carry, fa_a, fa_b, busy
  );
endinterface

// File: rtl/fa_rr_scheduler.sv
// Round-robin scheduler that time-shares one external 8-bit adder among four
// requesters. Operands are registered toward the adder, given SETTLE_CYC cycles
// to settle, then the sum/carry are captured and returned with a one-cycle ack.
// Optional feature: define FA_RR_SCHEDULER_SAT_EN to saturate res to 8'hFF on carry-out.
module fa_rr_scheduler #(
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic               clk,
  input  logic               rst,
  fa_rr_scheduler_if.slave   bus
);

  // A settle time of 0 is meaningless for a sampled adder; treat it as 1.
  localparam int unsigned SETTLE_EFF = (SETTLE_CYC == 0) ? 1 : SETTLE_CYC;
  localparam int unsigned CNT_W      = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [1:0]        win_q, win_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        gnt_q, gnt_d;
  logic [3:0]        ack_q, ack_d;
  logic [7:0]        res_q, res_d;
  logic              carry_q, carry_d;
  logic [7:0]        fa_a_q, fa_a_d;
  logic [7:0]        fa_b_q, fa_b_d;
  logic              busy_q, busy_d;

  logic [1:0]        win_idx;
  logic              win_vld;

  // Round-robin pick: first asserted request searching upward from ptr, mod 4.
  always_comb begin
    win_idx = ptr_q;
    win_vld = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (bus.req[2'(ptr_q + 2'(k))]) begin
        win_idx = 2'(ptr_q + 2'(k));
        win_vld = 1'b1;
      end
    end
  end

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      fa_a_q  <= '0;
      fa_b_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      fa_a_q  <= fa_a_d;
      fa_b_q  <= fa_b_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (win_vld) state_d = SETTLE;
      SETTLE:  if (cnt_q == '0) state_d = CAPTURE;
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath/output next values; operands are frozen for the whole transaction.
  always_comb begin
    ptr_d   = ptr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    res_d   = res_q;
    carry_d = carry_q;
    fa_a_d  = fa_a_q;
    fa_b_d  = fa_b_q;
    busy_d  = (state_d != IDLE);
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          win_d  = win_idx;
          fa_a_d = bus.req_a[{win_idx, 3'b000} +: 8];
          fa_b_d = bus.req_b[{win_idx, 3'b000} +: 8];
          gnt_d  = 4'b0001 << win_idx;
          cnt_d  = CNT_W'(SETTLE_EFF - 1);
        end
      end
      SETTLE: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      end
      CAPTURE: begin
`ifdef FA_RR_SCHEDULER_SAT_EN
        res_d   = bus.fa_cout ? 8'hFF : bus.fa_sum;
`else
        res_d   = bus.fa_sum;
`endif
        carry_d = bus.fa_cout;
        ack_d   = 4'b0001 << win_q;
        ptr_d   = 2'(win_q + 2'd1);
        gnt_d   = '0;
      end
      default: ;
    endcase
  end

  assign bus.gnt       = gnt_q;
  assign bus.ack       = ack_q;
  assign bus.res       = res_q;
  assign bus.res_carry = carry_q;
  assign bus.fa_a      = fa_a_q;
  assign bus.fa_b      = fa_b_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_fa_rr_scheduler.sv
// Directed bench for fa_rr_scheduler with an ideal combinational adder model.
module tb_fa_rr_scheduler;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  fa_rr_scheduler_if bus ();

  // Ideal adder: outputs already settled and digitised.
  assign {bus.fa_cout, bus.fa_sum} = 9'(bus.fa_a) + 9'(bus.fa_b);

  fa_rr_scheduler #(.SETTLE_CYC(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Wait (bounded) for an ack, counting negedges; timeout is reported as a failure.
  task automatic wait_ack(output int n, output logic [3:0] a);
    n = 0;
    a = '0;
    while (a == '0 && n < 20) begin
      @(negedge clk);
      n++;
      a = bus.ack;
    end
    if (a == '0) check("ack_timeout", 32'(n), 32'd4);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  int          n;
  logic [3:0]  a;
  logic [3:0]  fair_exp [4];
  logic [7:0]  ovf_exp;

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    rst     = 1'b1;
    bus.req   = '0;
    bus.req_a = '0;
    bus.req_b = '0;

    // Reset state
    do_reset();
    check("rst_gnt",   32'(bus.gnt),       32'h0);
    check("rst_ack",   32'(bus.ack),       32'h0);
    check("rst_res",   32'(bus.res),       32'h0);
    check("rst_carry", 32'(bus.res_carry), 32'h0);
    check("rst_fa_a",  32'(bus.fa_a),      32'h0);
    check("rst_fa_b",  32'(bus.fa_b),      32'h0);
    check("rst_busy",  32'(bus.busy),      32'h0);

    // Single request from requester 1: 0x12 + 0x34
    bus.req_a = 32'h0000_1200;
    bus.req_b = 32'h0000_3400;
    bus.req   = 4'b0010;
    @(negedge clk);
    check("s_gnt",  32'(bus.gnt),  32'h2);
    check("s_fa_a", 32'(bus.fa_a), 32'h12);
    check("s_fa_b", 32'(bus.fa_b), 32'h34);
    check("s_busy", 32'(bus.busy), 32'h1);
    check("s_ack0", 32'(bus.ack),  32'h0);
    bus.req_a = 32'h0000_AA00;
    bus.req_b = 32'h0000_5500;
    @(negedge clk);
    check("s_ack1",  32'(bus.ack),  32'h0);
    check("s_hold_a", 32'(bus.fa_a), 32'h12);
    @(negedge clk);
    check("s_ack2",  32'(bus.ack),  32'h0);
    check("s_hold_b", 32'(bus.fa_b), 32'h34);
    @(negedge clk);
    check("s_ack3",  32'(bus.ack),       32'h2);
    check("s_res",   32'(bus.res),       32'h46);
    check("s_carry", 32'(bus.res_carry), 32'h0);
    check("s_gnt_clr", 32'(bus.gnt),     32'h0);
    check("s_busy_lo", 32'(bus.busy),    32'h0);
    bus.req = '0;
    @(negedge clk);
    check("s_ack_pulse", 32'(bus.ack), 32'h0);
    check("s_res_hold",  32'(bus.res), 32'h46);
    check("s_idle",      32'(bus.busy), 32'h0);

    // All four at once after reset: order 0,1,2,3, 4 cycles apart, one idle cycle between
    do_reset();
    bus.req_a = 32'h4030_2010;
    bus.req_b = 32'h0403_0201;
    bus.req   = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wait_ack(n, a);
      check($sformatf("all_ack%0d", i), 32'(a), 32'(4'b0001 << i));
      check($sformatf("all_gap%0d", i), 32'(n), (i == 0) ? 32'd4 : 32'd3);
      check($sformatf("all_res%0d", i), 32'(bus.res), 32'(8'h11 * (i + 1)));
      check($sformatf("all_busy_lo%0d", i), 32'(bus.busy), 32'h0);
      bus.req[i] = 1'b0;
      if (i < 3) begin
        @(negedge clk);
        check($sformatf("all_busy_hi%0d", i), 32'(bus.busy), 32'h1);
      end
    end

    // Fairness: 0 and 2 held continuously -> 0,2,0,2
    fair_exp[0] = 4'b0001;
    fair_exp[1] = 4'b0100;
    fair_exp[2] = 4'b0001;
    fair_exp[3] = 4'b0100;
    bus.req = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      wait_ack(n, a);
      check($sformatf("fair_ack%0d", i), 32'(a), 32'(fair_exp[i]));
      check($sformatf("fair_gap%0d", i), 32'(n), 32'd4);
    end
    bus.req = '0;
    @(negedge clk);

    // Overflow 0xFF + 0x01 on requester 0
`ifdef FA_RR_SCHEDULER_SAT_EN
    ovf_exp = 8'hFF;
`else
    ovf_exp = 8'h00;
`endif
    bus.req_a = 32'h0000_00FF;
    bus.req_b = 32'h0000_0001;
    bus.req   = 4'b0001;
    wait_ack(n, a);
    check("ovf_ack",   32'(a),             32'h1);
    check("ovf_res",   32'(bus.res),       32'(ovf_exp));
    check("ovf_carry", 32'(bus.res_carry), 32'h1);
    bus.req = '0;
    @(negedge clk);

    // Reset during SETTLE of requester 3
    bus.req_a = 32'h0500_0007;
    bus.req_b = 32'h0600_0008;
    bus.req   = 4'b1000;
    @(negedge clk);
    check("rs_gnt", 32'(bus.gnt), 32'h8);
    rst     = 1'b1;
    bus.req = '0;
    @(negedge clk);
    rst = 1'b0;
    check("rs_gnt0",  32'(bus.gnt),  32'h0);
    check("rs_busy0", 32'(bus.busy), 32'h0);
    check("rs_res0",  32'(bus.res),  32'h0);
    a = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      a = a | bus.ack;
    end
    check("rs_no_ack", 32'(a), 32'h0);
    bus.req = 4'b1001;
    wait_ack(n, a);
    check("rs_first", 32'(a),       32'h1);
    check("rs_res1",  32'(bus.res), 32'h0F);
    bus.req[0] = 1'b0;
    wait_ack(n, a);
    check("rs_second", 32'(a),       32'h8);
    check("rs_res2",   32'(bus.res), 32'h0B);
    bus.req = '0;
    @(negedge clk);

    // Request withdrawn one cycle after grant still completes
    bus.req_a = 32'h007F_0000;
    bus.req_b = 32'h0001_0000;
    bus.req   = 4'b0100;
    @(negedge clk);
    check("wd_gnt", 32'(bus.gnt), 32'h4);
    bus.req = '0;
    wait_ack(n, a);
    check("wd_ack",   32'(a),             32'h4);
    check("wd_lat",   32'(n),             32'd3);
    check("wd_res",   32'(bus.res),       32'h80);
    check("wd_carry", 32'(bus.res_carry), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
